// File: rtl/gshare_branch_predictor_if.sv
// Lookup/update bundle between the fetch/execute pipeline (master) and the gshare predictor (slave).
interface gshare_branch_predictor_if #(
    parameter int PC_WIDTH  = 8,
    parameter int HIST_BITS = 8
);
    logic                 lookup_valid;
    logic [PC_WIDTH-1:0]  lookup_pc;
    logic                 prediction;
    logic [HIST_BITS-1:0] lookup_hist;
    logic                 update_valid;
    logic [PC_WIDTH-1:0]  update_pc;
    logic [HIST_BITS-1:0] update_hist;
    logic                 update_taken;
    logic                 update_mispredict;
    logic                 ready;

    modport master (
        output lookup_valid, lookup_pc,
        output update_valid, update_pc, update_hist, update_taken, update_mispredict,
        input  prediction, lookup_hist, ready
    );

    modport slave (
        input  lookup_valid, lookup_pc,
        input  update_valid, update_pc, update_hist, update_taken, update_mispredict,
        output prediction, lookup_hist, ready
    );
endinterface

// File: rtl/gshare_branch_predictor.sv
// Bimodal/gshare direction predictor: saturating-counter table cleared by a post-reset walk,
// speculative global history with repair on mispredict.
module gshare_branch_predictor #(
    parameter int PC_WIDTH   = 8,
    parameter int INDEX_BITS = 8,
    parameter int HIST_BITS  = 8,
    parameter int CTR_BITS   = 2,
    parameter int MODE       = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    gshare_branch_predictor_if.slave  bp
);
    localparam int                  DEPTH    = 1 << INDEX_BITS;
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;

    typedef enum logic {S_INIT, S_RUN} state_e;

    state_e                state_q, state_d;
    logic [INDEX_BITS-1:0] init_ptr_q, init_ptr_d;
    logic [HIST_BITS-1:0]  ghr_q, ghr_d;
    logic [CTR_BITS-1:0]   ctr_tbl_q [DEPTH];

    logic [INDEX_BITS-1:0] ghr_ext, upd_hist_ext, lk_idx, up_idx;
    logic [CTR_BITS-1:0]   up_ctr;
    logic                  run, pred;
    logic                  tbl_we;
    logic [INDEX_BITS-1:0] tbl_waddr;
    logic [CTR_BITS-1:0]   tbl_wdata;

    function automatic logic [CTR_BITS-1:0] ctr_inc(input logic [CTR_BITS-1:0] c);
        return (c == CTR_MAX) ? c : c + CTR_BITS'(1);
    endfunction

    function automatic logic [CTR_BITS-1:0] ctr_dec(input logic [CTR_BITS-1:0] c);
        return (c == '0) ? c : c - CTR_BITS'(1);
    endfunction

    // History only folds into the index in gshare mode; bimodal keeps the GHR but ignores it.
    always_comb begin
        ghr_ext      = '0;
        upd_hist_ext = '0;
        if (MODE != 0) begin
            ghr_ext      = INDEX_BITS'(ghr_q);
            upd_hist_ext = INDEX_BITS'(bp.update_hist);
        end
        lk_idx = bp.lookup_pc[INDEX_BITS-1:0] ^ ghr_ext;
        up_idx = bp.update_pc[INDEX_BITS-1:0] ^ upd_hist_ext;
        up_ctr = ctr_tbl_q[up_idx];
        run    = (state_q == S_RUN);
        pred   = run & ctr_tbl_q[lk_idx][CTR_BITS-1];
    end

    assign bp.prediction  = pred;
    assign bp.lookup_hist = ghr_q;
    assign bp.ready       = run;

    always_comb begin
        state_d    = state_q;
        init_ptr_d = init_ptr_q;
        ghr_d      = ghr_q;
        tbl_we     = 1'b0;
        tbl_waddr  = up_idx;
        tbl_wdata  = CTR_INIT;
        case (state_q)
            S_INIT: begin
                tbl_we     = 1'b1;
                tbl_waddr  = init_ptr_q;
                init_ptr_d = init_ptr_q + INDEX_BITS'(1);
                ghr_d      = '0;
                if (&init_ptr_q) state_d = S_RUN;
            end
            S_RUN: begin
                if (bp.update_valid) begin
                    tbl_we    = 1'b1;
                    tbl_wdata = bp.update_taken ? ctr_inc(up_ctr) : ctr_dec(up_ctr);
                end
                // Repair wins over the speculative shift: the younger lookup is on a squashed path.
                if (bp.update_valid && bp.update_mispredict)
                    ghr_d = HIST_BITS'({bp.update_hist, bp.update_taken});
                else if (bp.lookup_valid)
                    ghr_d = HIST_BITS'({ghr_q, pred});
            end
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_INIT;
            init_ptr_q <= '0;
            ghr_q      <= '0;
        end else begin
            state_q    <= state_d;
            init_ptr_q <= init_ptr_d;
            ghr_q      <= ghr_d;
        end
    end

    // No reset on the table so it can map onto a RAM; the init walk clears it instead.
    always_ff @(posedge clk) begin
        if (tbl_we) ctr_tbl_q[tbl_waddr] <= tbl_wdata;
    end
endmodule
